// File: rtl/fp16_pkg.sv
// fp16 field layout, checker FSM states and the result compare rule.
// FP16_CHK_NAN_EN: any expected NaN accepts any returned NaN.
package fp16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 10;
  localparam int MAN_HI   = 9;
  localparam int MAN_LO   = 0;

  localparam logic [4:0] EXP_ZERO = 5'h00;
  localparam logic [4:0] EXP_MAX  = 5'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fp16_match(
    input logic [15:0] got,
    input logic [15:0] ex,
    input int unsigned tol
  );
    logic [4:0]         ge;
    logic [4:0]         ee;
    logic [9:0]         gm;
    logic [9:0]         em;
    logic               ss;
    logic signed [16:0] d;
    logic [16:0]        ad;
    logic               ok;
    ge = got[EXP_HI:EXP_LO];
    ee = ex[EXP_HI:EXP_LO];
    gm = got[MAN_HI:MAN_LO];
    em = ex[MAN_HI:MAN_LO];
    ss = got[SIGN_BIT] == ex[SIGN_BIT];
    d  = $signed({2'b00, got[14:0]}) - $signed({2'b00, ex[14:0]});
    ad = d[16] ? 17'(-d) : 17'(d);
    if (ee == EXP_ZERO) begin
      // zero and subnormal expectations collapse to signless zero
      ok = (ge == EXP_ZERO) && (gm == 10'd0);
    end else if (ee == EXP_MAX) begin
`ifdef FP16_CHK_NAN_EN
      if (em != 10'd0)
        ok = (ge == EXP_MAX) && (gm != 10'd0);
      else
        ok = (ge == EXP_MAX) && (gm == 10'd0) && ss;
`else
      ok = (ge == EXP_MAX) && (gm == 10'd0) && ss && (em == em);
`endif
    end else begin
      ok = (ad <= 17'(tol)) && ss;
    end
    return ok;
  endfunction

endpackage

// File: rtl/fp16_chk_fifo.sv
// Expected-value FIFO: DEPTH x 16, flush has priority, no bypass paths.
module fp16_chk_fifo
  import fp16_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fp16_res_checker.sv
// In-order fp16 result checker with error count, sticky pass and mismatch report.
// FP16_CHK_NAN_EN relaxes the NaN compare (see fp16_pkg).
module fp16_res_checker
  import fp16_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int ULP_TOL = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_total,
  input  logic             i_exp_valid,
  output logic             o_exp_ready,
  input  logic [15:0]      i_exp,
  input  logic             i_res_valid,
  output logic             o_res_ready,
  input  logic [15:0]      i_res,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_mis_valid,
  output logic [CNT_W-1:0] o_mis_idx,
  output logic [15:0]      o_mis_got,
  output logic [15:0]      o_mis_exp
);

  state_t           state;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] checked;
  logic [CNT_W-1:0] checked_nxt;
  logic [15:0]      head;
  logic             run;
  logic             start_ok;
  logic             exp_fire;
  logic             res_fire;
  logic             full;
  logic             empty;
  logic             ok;

  assign run         = state == RUN;
  assign start_ok    = i_start & ~run;
  assign o_exp_ready = run & ~full;
  assign o_res_ready = run & ~empty;
  assign exp_fire    = i_exp_valid & o_exp_ready;
  assign res_fire    = i_res_valid & o_res_ready;
  assign ok          = fp16_match(i_res, head, ULP_TOL);
  assign checked_nxt = res_fire ? checked + 1'b1 : checked;
  assign o_busy      = run;
  assign o_done      = state == DONE;

  fp16_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (start_ok),
    .push  (exp_fire),
    .pop   (res_fire),
    .wdata (i_exp),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      total       <= '0;
      checked     <= '0;
      o_pass      <= 1'b1;
      o_err_cnt   <= '0;
      o_mis_valid <= 1'b0;
      o_mis_idx   <= '0;
      o_mis_got   <= '0;
      o_mis_exp   <= '0;
    end else begin
      o_mis_valid <= 1'b0;
      if (start_ok) begin
        state     <= RUN;
        total     <= i_total;
        checked   <= '0;
        o_err_cnt <= '0;
        o_pass    <= 1'b1;
      end else if (run) begin
        checked <= checked_nxt;
        if (res_fire && !ok) begin
          o_mis_valid <= 1'b1;
          o_mis_idx   <= checked;
          o_mis_got   <= i_res;
          o_mis_exp   <= head;
          o_pass      <= 1'b0;
          if (o_err_cnt != '1)
            o_err_cnt <= o_err_cnt + 1'b1;
        end
        // a zero-length run still spends one cycle here
        if (checked_nxt == total)
          state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_fp16_res_checker.sv
// Scoreboard bench: expected mismatch reports queued at issue, popped by a monitor.
module tb_fp16_res_checker;

  typedef struct packed {
    logic [15:0] idx;
    logic [15:0] got;
    logic [15:0] ex;
  } rep_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_total;
  logic        i_exp_valid;
  logic        o_exp_ready;
  logic [15:0] i_exp;
  logic        i_res_valid;
  logic        o_res_ready;
  logic [15:0] i_res;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [15:0] o_err_cnt;
  logic        o_mis_valid;
  logic [15:0] o_mis_idx;
  logic [15:0] o_mis_got;
  logic [15:0] o_mis_exp;

  rep_t        sb[$];
  int          n_vec  = 0;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] idx    = 0;
  logic [15:0] nan_err;

  always #5 i_clk = ~i_clk;

  fp16_res_checker dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_total     (i_total),
    .i_exp_valid (i_exp_valid),
    .o_exp_ready (o_exp_ready),
    .i_exp       (i_exp),
    .i_res_valid (i_res_valid),
    .o_res_ready (o_res_ready),
    .i_res       (i_res),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_err_cnt   (o_err_cnt),
    .o_mis_valid (o_mis_valid),
    .o_mis_idx   (o_mis_idx),
    .o_mis_got   (o_mis_got),
    .o_mis_exp   (o_mis_exp)
  );

  always @(negedge i_clk) begin
    if (!i_rst && o_mis_valid) begin
      rep_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL mis_report unexpected idx=%0d got=%h exp=%h",
                 o_mis_idx, o_mis_got, o_mis_exp);
      end else begin
        e = sb.pop_front();
        if ({o_mis_idx, o_mis_got, o_mis_exp} !== {e.idx, e.got, e.ex}) begin
          n_fail++;
          $display("FAIL mis_report idx/got/exp=%h/%h/%h required %h/%h/%h",
                   o_mis_idx, o_mis_got, o_mis_exp, e.idx, e.got, e.ex);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic start_run(input logic [15:0] t);
    i_start = 1'b1;
    i_total = t;
    @(negedge i_clk);
    i_start = 1'b0;
    idx = 0;
  endtask

  task automatic push_exp(input logic [15:0] v);
    int n = 0;
    i_exp = v;
    i_exp_valid = 1'b1;
    while (!o_exp_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'(n), 32'd0);
    else @(negedge i_clk);
    i_exp_valid = 1'b0;
  endtask

  task automatic send_res(input logic [15:0] got, input logic [15:0] ex, input bit ok);
    int n = 0;
    i_res = got;
    i_res_valid = 1'b1;
    while (!o_res_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 50) begin
      chk("res_timeout", 32'(n), 32'd0);
    end else begin
      if (!ok) sb.push_back('{idx: idx, got: got, ex: ex});
      idx++;
      n_vec++;
      @(negedge i_clk);
    end
    i_res_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef FP16_CHK_NAN_EN
    nan_err = 16'd1;
`else
    nan_err = 16'd2;
`endif
    i_rst = 1'b1; i_start = 0; i_total = 0;
    i_exp_valid = 0; i_exp = 0; i_res_valid = 0; i_res = 0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_state", {o_busy, o_done, o_pass, o_mis_valid, o_exp_ready, o_res_ready},
        32'b001000);
    chk("rst_err", 32'(o_err_cnt), 32'd0);

    start_run(16'd0);
    chk("t0_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    chk("t0_done", {o_done, o_pass}, 32'b11);
    chk("t0_err", 32'(o_err_cnt), 32'd0);

    start_run(16'd3);
    push_exp(16'h3C00); push_exp(16'h4000); push_exp(16'h4200);
    send_res(16'h3C01, 16'h3C00, 1);
    send_res(16'h4000, 16'h4000, 1);
    chk("ok3_not_done", 32'(o_done), 32'd0);
    send_res(16'h41FF, 16'h4200, 1);
    chk("ok3_done", {o_done, o_pass}, 32'b11);
    chk("ok3_err", 32'(o_err_cnt), 32'd0);

    start_run(16'd2);
    push_exp(16'h3C00); push_exp(16'h0000);
    send_res(16'h3C02, 16'h3C00, 0);
    send_res(16'h8000, 16'h0000, 1);
    chk("ulp_done_pass", {o_done, o_pass}, 32'b10);
    chk("ulp_err", 32'(o_err_cnt), 32'd1);

    start_run(16'd2);
    chk("restart_clear", {o_pass, o_err_cnt}, {1'b1, 16'd0});
    push_exp(16'h7C00); push_exp(16'h7E00);
    send_res(16'hFC00, 16'h7C00, 0);
`ifdef FP16_CHK_NAN_EN
    send_res(16'h7E01, 16'h7E00, 1);
`else
    send_res(16'h7E01, 16'h7E00, 0);
`endif
    @(negedge i_clk);
    chk("inf_nan_err", 32'(o_err_cnt), 32'(nan_err));
    chk("inf_nan_pass", 32'(o_pass), 32'd0);

    start_run(16'd9);
    chk("full_empty_rdy", 32'(o_res_ready), 32'd0);
    for (int i = 0; i < 8; i++) push_exp(16'h3C00 + 16'(i));
    chk("full_exp_ready", 32'(o_exp_ready), 32'd0);
    chk("full_res_ready", 32'(o_res_ready), 32'd1);
    i_exp = 16'h5555;
    i_exp_valid = 1'b1;
    send_res(16'h3C00, 16'h3C00, 1);
    i_exp_valid = 1'b0;
    chk("full_refused_cnt7", 32'(o_exp_ready), 32'd1);
    for (int i = 1; i < 8; i++) send_res(16'h3C00 + 16'(i), 16'h3C00 + 16'(i), 1);
    push_exp(16'h4400);
    send_res(16'h4400, 16'h4400, 1);
    chk("full_done", {o_done, o_pass, o_err_cnt}, {2'b11, 16'd0});

    start_run(16'd5);
    for (int i = 0; i < 5; i++) push_exp(16'h4000 + 16'(i));
    send_res(16'h4000, 16'h4000, 1);
    send_res(16'h4001, 16'h4001, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midrst_state", {o_busy, o_done, o_pass, o_mis_valid, o_exp_ready, o_res_ready},
        32'b001000);
    chk("midrst_err", 32'(o_err_cnt), 32'd0);
    start_run(16'd1);
    chk("midrst_fifo_empty", 32'(o_res_ready), 32'd0);
    push_exp(16'h4800);
    send_res(16'h4800, 16'h4800, 1);
    chk("midrst_rerun", {o_done, o_pass, o_err_cnt}, {2'b11, 16'd0});

    repeat (3) @(negedge i_clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
